// File: rtl/bbus_seq_if.sv
// Requester handshake plus shared device bus of the W5300/SL811 bus sequencer.
// master = requesters and devices (environment side), slave = the sequencer.
interface bbus_seq_if;
  logic [1:0]       rq_req;
  logic [1:0]       rq_dev;
  logic [1:0]       rq_rnw;
  logic [1:0][9:0]  rq_addr;
  logic [1:0][7:0]  rq_wdata;
  logic [1:0]       rq_ack;
  logic [7:0]       rdata;
  logic [9:0]       baddr;
  logic             w5300_cs_n;
  logic             sl811_cs_n;
  logic             brd_n;
  logic             bwr_n;
  logic [7:0]       bd_in;
  logic [7:0]       bd_out;
  logic             bd_oe;

  modport master (
    output rq_req, rq_dev, rq_rnw, rq_addr, rq_wdata, bd_in,
    input  rq_ack, rdata, baddr, w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_out, bd_oe
  );

  modport slave (
    input  rq_req, rq_dev, rq_rnw, rq_addr, rq_wdata, bd_in,
    output rq_ack, rdata, baddr, w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_out, bd_oe
  );
endinterface

// File: rtl/bbus_seq.sv
// Two-requester sequencer for the shared W5300/SL811 parallel bus (setup/strobe/hold).
// Define BBUS_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module bbus_seq #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned STB_W53   = 3,
  parameter int unsigned STB_SL8   = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  bbus_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        gnt_reg, gnt_next;
  logic        dev_reg, dev_next;
  logic        rnw_reg, rnw_next;
  logic        last_reg, last_next;
  logic [9:0]  baddr_reg, baddr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        w53_cs_n_reg, w53_cs_n_next;
  logic        sl8_cs_n_reg, sl8_cs_n_next;
  logic        brd_n_reg, brd_n_next;
  logic        bwr_n_reg, bwr_n_next;
  logic        bd_oe_reg, bd_oe_next;
  logic [1:0]  ack_reg, ack_next;
  logic        win;
  logic        active;

  // last_reg holds the requester acked last; reset value 1 favours requester 0 first
  always_comb begin
    win = (bus.rq_req == 2'b10);
`ifdef BBUS_RR_EN
    if (bus.rq_req == 2'b11)
      win = ~last_reg;
`endif
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    dev_next   = dev_reg;
    rnw_next   = rnw_reg;
    last_next  = last_reg;
    baddr_next = baddr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.rq_req) begin
          state_next = SETUP;
          cnt_next   = 3'(SETUP_CYC - 1);
          gnt_next   = win;
          dev_next   = bus.rq_dev[win];
          rnw_next   = bus.rq_rnw[win];
          baddr_next = bus.rq_dev[win] ? {9'd0, bus.rq_addr[win][0]} : bus.rq_addr[win];
          wdata_next = bus.rq_wdata[win];
        end
      end
      SETUP: begin
        if (cnt_reg == 3'd0) begin
          state_next = STROBE;
          cnt_next   = dev_reg ? 3'(STB_SL8 - 1) : 3'(STB_W53 - 1);
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 3'd0) begin
          state_next = HOLD;
          cnt_next   = 3'(HOLD_CYC - 1);
          if (rnw_reg)
            rdata_next = bus.bd_in;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 3'd0) begin
          state_next = IDLE;
          last_next  = gnt_reg;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are derived from the next state so they change on the same edge as the FSM
  always_comb begin
    active        = (state_next != IDLE);
    w53_cs_n_next = !(active && !dev_next);
    sl8_cs_n_next = !(active && dev_next);
    brd_n_next    = !(state_next == STROBE && rnw_next);
    bwr_n_next    = !(state_next == STROBE && !rnw_next);
    bd_oe_next    = active && !rnw_next;
    ack_next      = 2'b00;
    if (state_next == HOLD && cnt_next == 3'd0)
      ack_next = gnt_next ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      gnt_reg      <= 1'b0;
      dev_reg      <= 1'b0;
      rnw_reg      <= 1'b0;
      last_reg     <= 1'b1;
      baddr_reg    <= 10'd0;
      wdata_reg    <= 8'd0;
      rdata_reg    <= 8'd0;
      w53_cs_n_reg <= 1'b1;
      sl8_cs_n_reg <= 1'b1;
      brd_n_reg    <= 1'b1;
      bwr_n_reg    <= 1'b1;
      bd_oe_reg    <= 1'b0;
      ack_reg      <= 2'b00;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= gnt_next;
      dev_reg      <= dev_next;
      rnw_reg      <= rnw_next;
      last_reg     <= last_next;
      baddr_reg    <= baddr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      w53_cs_n_reg <= w53_cs_n_next;
      sl8_cs_n_reg <= sl8_cs_n_next;
      brd_n_reg    <= brd_n_next;
      bwr_n_reg    <= bwr_n_next;
      bd_oe_reg    <= bd_oe_next;
      ack_reg      <= ack_next;
    end
  end

  assign bus.rq_ack     = ack_reg;
  assign bus.rdata      = rdata_reg;
  assign bus.baddr      = baddr_reg;
  assign bus.w5300_cs_n = w53_cs_n_reg;
  assign bus.sl811_cs_n = sl8_cs_n_reg;
  assign bus.brd_n      = brd_n_reg;
  assign bus.bwr_n      = bwr_n_reg;
  assign bus.bd_out     = wdata_reg;
  assign bus.bd_oe      = bd_oe_reg;

endmodule

// File: tb/tb_bbus_seq.sv
// Randomized self-checking bench for bbus_seq against a transaction-level model
// with a simple W5300/SL811 register-file device on the shared bus.
module tb_bbus_seq;
  localparam int SETUP_CYC = 1;
  localparam int STB_W53   = 3;
  localparam int STB_SL8   = 2;
  localparam int HOLD_CYC  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bbus_seq_if bus ();

  bbus_seq #(
    .SETUP_CYC(SETUP_CYC), .STB_W53(STB_W53), .STB_SL8(STB_SL8), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Device contents as seen on the bus, and the reference contents implied by issued writes
  logic [7:0] dmem_w53 [1024];
  logic [7:0] dmem_sl  [2];
  logic [7:0] ref_w53  [1024];
  logic [7:0] ref_sl   [2];
  int         model_last = 1;

  assign bus.bd_in = (!bus.sl811_cs_n) ? dmem_sl[bus.baddr[0]] : dmem_w53[bus.baddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Device write capture and bus-level invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && !bus.bwr_n) begin
      if (!bus.w5300_cs_n) dmem_w53[bus.baddr] = bus.bd_out;
      else if (!bus.sl811_cs_n) dmem_sl[bus.baddr[0]] = bus.bd_out;
    end
    check("strb_excl", {31'd0, (!bus.brd_n && !bus.bwr_n)}, 32'd0);
    check("cs_excl", {31'd0, (!bus.w5300_cs_n && !bus.sl811_cs_n)}, 32'd0);
    check("oe_on_read", {31'd0, (bus.bd_oe && !bus.brd_n)}, 32'd0);
    check("oe_idle", {31'd0, (bus.bd_oe && bus.w5300_cs_n && bus.sl811_cs_n)}, 32'd0);
  end

  function automatic int expected_winner(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
`ifdef BBUS_RR_EN
    return (model_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic do_access(input int r, input bit dev, input bit rnw,
                           input logic [9:0] addr, input logic [7:0] wd, input bit drop);
    int n = 0, cs_cnt = 0, stb_cnt = 0, oe_cnt = 0, bad = 0;
    int stb;
    bit done = 0;
    logic [9:0] ea;
    logic [7:0] exp_rd;
    logic cs_sel;
    stb    = dev ? STB_SL8 : STB_W53;
    ea     = dev ? {9'd0, addr[0]} : addr;
    exp_rd = dev ? ref_sl[addr[0]] : ref_w53[addr];
    bus.rq_dev[r]   = dev;
    bus.rq_rnw[r]   = rnw;
    bus.rq_addr[r]  = addr;
    bus.rq_wdata[r] = wd;
    bus.rq_req[r]   = 1'b1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      cs_sel = dev ? bus.sl811_cs_n : bus.w5300_cs_n;
      if (!cs_sel) cs_cnt++;
      if (!(rnw ? bus.brd_n : bus.bwr_n)) stb_cnt++;
      if (!(rnw ? bus.bwr_n : bus.brd_n)) bad++;
      if (bus.bd_oe) oe_cnt++;
      if (!cs_sel && bus.baddr !== ea) bad++;
      if (!cs_sel && !rnw && bus.bd_out !== wd) bad++;
      if (drop && n == 2) bus.rq_req[r] = 1'b0;
      if (bus.rq_ack != 2'b00) begin
        done = 1;
        check("ack_vec", {30'd0, bus.rq_ack}, 32'd1 << r);
        if (rnw) check("rdata", {24'd0, bus.rdata}, {24'd0, exp_rd});
      end
    end
    bus.rq_req[r] = 1'b0;
    check("ack_seen", {31'd0, done}, 32'd1);
    check("latency", n + 1, 1 + SETUP_CYC + stb + HOLD_CYC);
    check("cs_width", cs_cnt, SETUP_CYC + stb + HOLD_CYC);
    check("stb_width", stb_cnt, stb);
    check("oe_width", oe_cnt, rnw ? 0 : SETUP_CYC + stb + HOLD_CYC);
    check("bus_vals", bad, 0);
    @(posedge clk); #1;
    check("idle_cs", {30'd0, bus.w5300_cs_n, bus.sl811_cs_n}, 32'd3);
    if (!rnw) begin
      if (dev) ref_sl[addr[0]] = wd;
      else ref_w53[addr] = wd;
    end
    model_last = r;
    $display("[TB] access r=%0d dev=%0d rnw=%0d addr=0x%0h wd=0x%0h lat=%0d", r, dev, rnw, addr, wd, n + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acks;
    int exp_w;
    bit prev_ack;
    for (int i = 0; i < 1024; i++) begin
      dmem_w53[i] = 8'($urandom);
      ref_w53[i]  = dmem_w53[i];
    end
    for (int i = 0; i < 2; i++) begin
      dmem_sl[i] = 8'($urandom);
      ref_sl[i]  = dmem_sl[i];
    end
    bus.rq_req = 2'b00; bus.rq_dev = 2'b00; bus.rq_rnw = 2'b00;
    bus.rq_addr = '0; bus.rq_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", {30'd0, bus.w5300_cs_n, bus.sl811_cs_n}, 32'd3);
    check("rst_strb", {30'd0, bus.brd_n, bus.bwr_n}, 32'd3);
    check("rst_oe", {31'd0, bus.bd_oe}, 32'd0);
    check("rst_vals", {bus.baddr, bus.bd_out, bus.rdata}, 32'd0);
    check("rst_ack", {30'd0, bus.rq_ack}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default-parameter write to W5300 and SL811 read of a known register
    do_access(0, 1'b0, 1'b0, 10'h2AB, 8'h5A, 1'b0);
    dmem_sl[1] = 8'hC3; ref_sl[1] = 8'hC3;
    do_access(1, 1'b1, 1'b1, 10'h001, 8'h00, 1'b0);
    do_access(0, 1'b0, 1'b1, 10'h2AB, 8'h00, 1'b0);

    for (int t = 0; t < 24; t++) begin
      do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                10'($urandom_range(0, 10'h3FE)), 8'($urandom), ($urandom_range(0, 2) == 0));
    end

    // Both requesters asserting continuously
    bus.rq_dev = 2'b00; bus.rq_rnw = 2'b11;
    bus.rq_addr[0] = 10'h010; bus.rq_addr[1] = 10'h020;
    bus.rq_req = 2'b11;
    acks = 0; k = 0; prev_ack = 0;
    while (acks < 6 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (prev_ack) check("gap_cs", {30'd0, bus.w5300_cs_n, bus.sl811_cs_n}, 32'd3);
      prev_ack = 0;
      if (bus.rq_ack != 2'b00) begin
        exp_w = expected_winner(2'b11);
        check("arb_order", {30'd0, bus.rq_ack}, 32'd1 << exp_w);
        $display("[TB] arb ack=%b expected_req=%0d", bus.rq_ack, exp_w);
        model_last = exp_w;
        acks++;
        prev_ack = 1;
        if (acks == 6) bus.rq_req = 2'b00;
      end
    end
    check("arb_done", acks, 6);
    bus.rq_req = 2'b00;
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a strobe
    bus.rq_dev[0] = 1'b0; bus.rq_rnw[0] = 1'b0;
    bus.rq_addr[0] = 10'h3FF; bus.rq_wdata[0] = 8'hA5;
    bus.rq_req[0] = 1'b1;
    k = 0;
    while (bus.bwr_n && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("stb_seen", {31'd0, bus.bwr_n}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", {30'd0, bus.w5300_cs_n, bus.sl811_cs_n}, 32'd3);
    check("abort_strb", {30'd0, bus.brd_n, bus.bwr_n}, 32'd3);
    check("abort_ack", {30'd0, bus.rq_ack}, 32'd0);
    @(posedge clk); #1;
    check("abort_ack2", {30'd0, bus.rq_ack}, 32'd0);
    bus.rq_req = 2'b00;
    rst_n = 1'b1;
    model_last = 1;
    $display("[TB] reset abort during strobe");
    @(posedge clk); #1;
    check("post_rst_ack", {30'd0, bus.rq_ack}, 32'd0);
    do_access(0, 1'b0, 1'b1, 10'h2AB, 8'h00, 1'b0);
    do_access(1, 1'b1, 1'b0, 10'h3FE, 8'h77, 1'b1);
    do_access(0, 1'b1, 1'b1, 10'h2A0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bbus_seq.md
BBUS_SEQ -- requirements
Module: bbus_seq

Interface
REQ-001 Parameter SETUP_CYC, default 1: clocks of address/CS setup before the strobe (range 1..3).
REQ-002 Parameter STB_W53, default 3: strobe width in clocks for W5300 accesses (range 1..7).
REQ-003 Parameter STB_SL8, default 2: strobe width in clocks for SL811 accesses (range 1..7).
REQ-004 Parameter HOLD_CYC, default 1: clocks of CS/address/data hold after the strobe (range 1..3).
REQ-005 clk  in  1  sole clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rq_req  in  2  per-requester access request, level, held until ack (requester 0 = Z80 bridge, requester 1 = poller).
REQ-008 rq_dev  in  2  per requester: 0 = W5300, 1 = SL811.
REQ-009 rq_rnw  in  2  per requester: 1 = read, 0 = write.
REQ-010 rq_addr  in  2x10  per-requester device address; SL811 uses bit 0 only.
REQ-011 rq_wdata  in  2x8  per-requester write data.
REQ-012 rq_ack  out  2  one-clock completion pulse per requester.
REQ-013 rdata  out  8  read data, valid in the rq_ack clock and held until the next read completes.
REQ-014 baddr  out  10  device address bus.
REQ-015 w5300_cs_n, sl811_cs_n  out  1 each  chip selects.
REQ-016 brd_n, bwr_n  out  1 each  shared read/write strobes.
REQ-017 bd_in  in  8  device bus input; bd_out  out  8; bd_oe  out  1  data bus drive enable.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD; all outputs registered.
REQ-019 IDLE: when any rq_req is 1, grant per REQ-030/031, latch the dev/rnw/addr/wdata of the granted requester, go to SETUP.
REQ-020 SETUP: assert the selected cs_n and baddr (and bd_oe with bd_out for writes); remain SETUP_CYC clocks, then go to STROBE.
REQ-021 STROBE: assert brd_n (read) or bwr_n (write) for STB_W53 or STB_SL8 clocks according to the latched dev.
REQ-022 Read: sample bd_in into rdata on the final STROBE clock, before the strobe deasserts.
REQ-023 HOLD: strobes deasserted; cs_n, baddr and bd_oe held for HOLD_CYC clocks; rq_ack of the granted requester pulses on the last HOLD clock; then go to IDLE.
REQ-024 Total access time is 1 + SETUP_CYC + STB + HOLD_CYC clocks from the first request to the ack; the default W5300 access takes 6 clocks.
REQ-025 brd_n and bwr_n are never low together; at most one cs_n is low at a time.
REQ-026 bd_oe is 0 whenever brd_n is 0 and in IDLE.
REQ-027 The sequencer returns to IDLE for at least one clock between accesses, with cs_n high in that clock.
REQ-028 Dropping rq_req mid-access has no effect; the access completes and ack is still issued.
REQ-029 An unused rq_addr upper bit for SL811 drives baddr[9:1] to 0.

Arbitration
REQ-030 Simultaneous requests in IDLE: grant per the REQ-037/038 policy.
REQ-031 The grant is fixed from IDLE exit until HOLD completion; no preemption.

Reset
REQ-032 While rst_n=0: state is IDLE; cs_n, brd_n and bwr_n are 1; bd_oe is 0; baddr, bd_out and rdata are 0; rq_ack is 0; the round-robin pointer selects requester 0 first.
REQ-033 Reset asserted mid-access aborts immediately and asynchronously, with strobes and cs_n going high, and issues no ack.
REQ-034 After reset deassertion, the first request is serviced from IDLE with no extra latency.

Configuration
REQ-035 Macro BBUS_RR_EN selects the arbitration policy.
REQ-036 BBUS_RR_EN has no other effect.
REQ-037 With BBUS_RR_EN defined: round-robin arbitration; on a simultaneous request, the requester not granted last wins; the pointer updates on each ack.
REQ-038 Without BBUS_RR_EN: fixed priority, with requester 0 always winning simultaneous requests.

Verification
REQ-039 Default parameters; requester 0 writes W5300 addr 0x2AB with data 0x5A -> cs_n low 5 clocks, bwr_n low exactly 3 clocks, baddr=0x2AB, bd_out=0x5A, rq_ack[0] pulses at clock 6.
REQ-040 Requester 1 reads SL811 addr 1 with bd_in=0xC3 -> brd_n low 2 clocks, bd_oe=0 throughout, rdata=0xC3 at rq_ack[1].
REQ-041 Both requesters requesting continuously, BBUS_RR_EN defined -> acks alternate 0,1,0,1; without the macro -> only requester 0 is acked.
REQ-042 rst_n pulsed low during STROBE -> strobes and cs_n high in the same timestep, no ack, next request completes normally.
REQ-043 Back-to-back requests -> at least one IDLE clock with both cs_n high between accesses; brd_n and bwr_n are never low together (continuous assertion).
